// File: rtl/traffic_pkg.sv
// Shared encodings and default timings for the four-way traffic scheduler.
package traffic_pkg;

  // One-hot lamp encodings driven onto each approach's light bundle.
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  localparam int DEF_MIN_GREEN = 8;
  localparam int DEF_MAX_GREEN = 32;
  localparam int DEF_YELLOW_T  = 4;
  localparam int DEF_ALLRED_T  = 2;

  // Lamp for approach 'me' given the registered phase and owning approach.
  function automatic logic [2:0] light_for(phase_e ph, logic [1:0] owner, logic [1:0] me);
    logic [2:0] l;
    l = LIGHT_RED;
    if (owner == me) begin
      case (ph)
        PH_GREEN:  l = LIGHT_GREEN;
        PH_YELLOW: l = LIGHT_YELLOW;
        default:   l = LIGHT_RED;
      endcase
    end
    return l;
  endfunction

endpackage

// File: rtl/dir_rr_picker.sv
// Round-robin scan: nearest requesting approach after cur_dir (cur+1, +2, +3 mod 4).
module dir_rr_picker (
  input  logic [3:0] req,
  input  logic [1:0] cur_dir,
  output logic       found,
  output logic [1:0] next_dir
);

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    found    = 1'b0;
    next_dir = cur_dir;
    for (int k = 3; k >= 1; k--) begin
      if (req[cur_dir + 2'(k)]) begin
        found    = 1'b1;
        next_dir = cur_dir + 2'(k);
      end
    end
  end

endmodule

// File: rtl/traffic_scheduler.sv
// Four-approach signal controller: ALL_RED -> GREEN -> YELLOW -> ALL_RED with
// demand-driven green termination, round-robin hand-off and emergency preemption.
module traffic_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T
) (
  input  logic       clk,
  input  logic       rst_an,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
  output logic [2:0] n_lights,
  output logic [2:0] s_lights,
  output logic [2:0] e_lights,
  output logic [2:0] w_lights,
  output logic [1:0] cur_dir,
  output logic [1:0] phase,
  output logic       green_start
);

  if (MIN_GREEN < 1 || MIN_GREEN > MAX_GREEN || MAX_GREEN > 255 ||
      YELLOW_T < 1 || YELLOW_T > 255 || ALLRED_T < 1 || ALLRED_T > 255) begin : g_param_check
    $error("traffic_scheduler: timing parameters out of range");
  end

  localparam logic [7:0] MIN_G8   = 8'(MIN_GREEN);
  localparam logic [7:0] MAX_G8   = 8'(MAX_GREEN);
  localparam logic [7:0] YEL_LAST = 8'(YELLOW_T - 1);
  localparam logic [7:0] RED_LAST = 8'(ALLRED_T - 1);

  phase_e     ph_q, ph_d;
  logic [1:0] dir_q, nxt_q;
  logic [7:0] g_q, tmr_q;
  logic       gs_q;

  logic       rr_found;
  logic [1:0] rr_dir;
  logic       pre_other, pre_hold, at_max, green_done, yel_done, red_done;
  logic [1:0] pend_dir;

  dir_rr_picker u_pick (
    .req      (req),
    .cur_dir  (dir_q),
    .found    (rr_found),
    .next_dir (rr_dir)
  );

  // Termination and timer decisions for the current cycle.
  always_comb begin
    pre_other  = preempt && (preempt_dir != dir_q);
    pre_hold   = preempt && (preempt_dir == dir_q);
    // Preemption toward the owner keeps it green past the MAX_GREEN cap.
    at_max     = (g_q == MAX_G8) && !pre_hold;
    green_done = pre_other ||
                 ((g_q >= MIN_G8) && rr_found && (!req[dir_q] || at_max));
    yel_done   = (tmr_q == YEL_LAST);
    red_done   = (tmr_q == RED_LAST);
    // An active preemption overrides the latched successor during clearance.
    pend_dir   = preempt ? preempt_dir : nxt_q;
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) ph_q <= PH_ALL_RED;
    else         ph_q <= ph_d;
  end

  // Next-phase logic; only the fixed cycle of transitions is reachable.
  always_comb begin
    ph_d = ph_q;
    unique case (ph_q)
      PH_ALL_RED: if (red_done)   ph_d = PH_GREEN;
      PH_GREEN:   if (green_done) ph_d = PH_YELLOW;
      PH_YELLOW:  if (yel_done)   ph_d = PH_ALL_RED;
      default:                    ph_d = PH_ALL_RED;
    endcase
  end

  // Timers, green counter, owner/successor latches and the green_start pulse.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      dir_q <= 2'd0;
      nxt_q <= 2'd0;
      g_q   <= 8'd0;
      tmr_q <= 8'd0;
      gs_q  <= 1'b0;
    end else begin
      gs_q <= (ph_q == PH_ALL_RED) && red_done;
      unique case (ph_q)
        PH_ALL_RED: begin
          nxt_q <= pend_dir;
          if (red_done) begin
            tmr_q <= 8'd0;
            dir_q <= pend_dir;
            g_q   <= 8'd1;
          end else begin
            tmr_q <= tmr_q + 8'd1;
          end
        end
        PH_GREEN: begin
          if (green_done) begin
            nxt_q <= pre_other ? preempt_dir : rr_dir;
            tmr_q <= 8'd0;
          end else if (g_q != MAX_G8) begin
            g_q <= g_q + 8'd1;
          end
        end
        PH_YELLOW: begin
          nxt_q <= pend_dir;
          if (yel_done) tmr_q <= 8'd0;
          else          tmr_q <= tmr_q + 8'd1;
        end
        default: tmr_q <= 8'd0;
      endcase
    end
  end

  assign n_lights    = light_for(ph_q, dir_q, DIR_N);
  assign s_lights    = light_for(ph_q, dir_q, DIR_S);
  assign e_lights    = light_for(ph_q, dir_q, DIR_E);
  assign w_lights    = light_for(ph_q, dir_q, DIR_W);
  assign cur_dir     = dir_q;
  assign phase       = ph_q;
  assign green_start = gs_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Scoreboard bench: a cycle-level reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_traffic_scheduler;

  localparam int MING = 8;
  localparam int MAXG = 32;
  localparam int YT   = 4;
  localparam int AT   = 2;

  logic       clk = 1'b0;
  logic       rst_an;
  logic [3:0] req;
  logic       preempt;
  logic [1:0] preempt_dir;
  logic [2:0] n_l, s_l, e_l, w_l;
  logic [1:0] cur_dir, phase;
  logic       green_start;

  always #5 clk = ~clk;

  traffic_scheduler #(.MIN_GREEN(MING), .MAX_GREEN(MAXG), .YELLOW_T(YT), .ALLRED_T(AT)) dut (
    .clk(clk), .rst_an(rst_an), .req(req), .preempt(preempt), .preempt_dir(preempt_dir),
    .n_lights(n_l), .s_lights(s_l), .e_lights(e_l), .w_lights(w_l),
    .cur_dir(cur_dir), .phase(phase), .green_start(green_start)
  );

  typedef struct packed {
    logic [2:0] n, s, e, w;
    logic [1:0] dir, ph;
    logic       gs;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;

  // Reference model state: phase (0 red,1 green,2 yellow), owner, successor,
  // green cycles so far, cycles spent in the current clearance phase.
  int m_ph, m_dir, m_next, m_g, m_t;
  bit m_gs;

  task automatic model_reset();
    m_ph = 0; m_dir = 0; m_next = 0; m_g = 0; m_t = 0; m_gs = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic p, input logic [1:0] pd);
    int  other;
    bit  leave;
    m_gs = 0;
    case (m_ph)
      0: begin
        if (p) m_next = pd;
        m_t++;
        if (m_t == AT) begin
          m_ph = 1; m_dir = m_next; m_g = 1; m_gs = 1; m_t = 0;
        end
      end
      1: begin
        other = -1;
        for (int k = 1; k <= 3; k++)
          if (other < 0 && r[(m_dir + k) % 4]) other = (m_dir + k) % 4;
        if (p && pd != m_dir) begin
          leave  = 1;
          m_next = pd;
        end else begin
          leave = (m_g >= MING) && (other >= 0) &&
                  (!r[m_dir] || (m_g == MAXG && !(p && pd == m_dir)));
          if (leave) m_next = other;
        end
        if (leave) begin
          m_ph = 2; m_t = 0;
        end else if (m_g < MAXG) m_g++;
      end
      default: begin
        if (p) m_next = pd;
        m_t++;
        if (m_t == YT) begin
          m_ph = 0; m_t = 0;
        end
      end
    endcase
  endtask

  function automatic logic [2:0] lamp(int a);
    if (m_dir != a || m_ph == 0) return 3'b100;
    return (m_ph == 1) ? 3'b001 : 3'b010;
  endfunction

  function automatic exp_t mk_exp();
    exp_t e;
    e.n = lamp(0); e.s = lamp(1); e.e = lamp(2); e.w = lamp(3);
    e.dir = 2'(m_dir); e.ph = 2'(m_ph); e.gs = m_gs;
    return e;
  endfunction

  // One clock: advance the model with the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_an) model_reset();
    else         model_step(req, preempt, preempt_dir);
    exp_q.push_back(mk_exp());
  endtask

  task automatic check_reset_now(input string nm);
    checks++;
    if (n_l == 3'b100 && s_l == 3'b100 && e_l == 3'b100 && w_l == 3'b100 &&
        phase == 2'd0 && cur_dir == 2'd0 && green_start == 1'b0)
      passes++;
    else
      $display("FAIL %s: got n=%b s=%b e=%b w=%b ph=%0d dir=%0d gs=%b, expected all 100 ph=0 dir=0 gs=0",
               nm, n_l, s_l, e_l, w_l, phase, cur_dir, green_start);
  endtask

  // Asynchronous reset asserted between edges, checked before any edge.
  task automatic do_reset(input string nm);
    #1 rst_an = 1'b0;
    #1 check_reset_now(nm);
    exp_q.delete();
    model_reset();
    exp_q.push_back(mk_exp());
    tick();
    tick();
    #1 rst_an = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  exp_t e_pop, act;
  int   nonred;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_pop = exp_q.pop_front();
      act   = {n_l, s_l, e_l, w_l, cur_dir, phase, green_start};
      checks++;
      if (act === e_pop) passes++;
      else
        $display("FAIL scoreboard @%0t: got n=%b s=%b e=%b w=%b dir=%0d ph=%0d gs=%b, expected n=%b s=%b e=%b w=%b dir=%0d ph=%0d gs=%b",
                 $time, act.n, act.s, act.e, act.w, act.dir, act.ph, act.gs,
                 e_pop.n, e_pop.s, e_pop.e, e_pop.w, e_pop.dir, e_pop.ph, e_pop.gs);
      nonred = (n_l != 3'b100) + (s_l != 3'b100) + (e_l != 3'b100) + (w_l != 3'b100);
      checks++;
      if (nonred <= 1) passes++;
      else $display("FAIL exclusive @%0t: got %0d non-red approaches, expected at most 1", $time, nonred);
    end
  end

  initial begin
    bit seen;
    rst_an = 1'b0; req = 4'b0; preempt = 1'b0; preempt_dir = 2'd0;
    model_reset();
    #3 check_reset_now("reset_initial");
    tick(); tick();
    #1 rst_an = 1'b1;

    // Idle: two red cycles, then N green resting for 100 cycles.
    repeat (102) tick();

    // E demand from the first N green cycle: min green then hand-off to E.
    req = 4'b0100;
    do_reset("reset_before_e");
    repeat (30) tick();

    // From E green, N and S request, E idle: wrap to N.
    req = 4'b0011;
    repeat (25) tick();

    // N keeps requesting against S: capped at MAX green, then S.
    do_reset("reset_before_max");
    repeat (50) tick();

    // Preempt toward W at g=3.
    req = 4'b0000;
    do_reset("reset_before_pre");
    repeat (4) tick();
    preempt = 1'b1; preempt_dir = 2'd3;
    repeat (10) tick();
    // Preempt on the owner holds green past MAX against conflicting demand.
    req = 4'b0110;
    repeat (45) tick();
    preempt = 1'b0;
    repeat (20) tick();

    // Reset dropped in the middle of YELLOW.
    req = 4'b0100;
    do_reset("reset_before_yel");
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (m_ph == 2) seen = 1;
    end
    checks++;
    if (seen) passes++;
    else $display("FAIL reach_yellow: got no yellow within 40 cycles, expected yellow");
    tick();
    do_reset("reset_mid_yellow");

    // Randomised demand and preemption.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) req = 4'($urandom);
      if (preempt) begin
        if ($urandom_range(9) == 0) preempt = 1'b0;
      end else if ($urandom_range(59) == 0) begin
        preempt = 1'b1; preempt_dir = 2'($urandom);
      end
      tick();
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
